// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline buffers: stage limit, ID/EX and EX/MEM
// bundle field positions, their bubble encodings, and a small popcount helper.
package pipe_pkg;

  localparam int unsigned PIPE_MAX_STAGES = 8;

  // ID/EX bundle, 91 bits: eight control bits, two operands, register ids, function code
  localparam int unsigned IDEX_W          = 91;
  localparam int unsigned IDEX_REG_WRITE  = 90;
  localparam int unsigned IDEX_MEM_TO_REG = 89;
  localparam int unsigned IDEX_MEM_READ   = 88;
  localparam int unsigned IDEX_MEM_WRITE  = 87;
  localparam int unsigned IDEX_BRANCH     = 86;
  localparam int unsigned IDEX_ALU_SRC    = 85;
  localparam int unsigned IDEX_ALU_OP_HI  = 84;
  localparam int unsigned IDEX_ALU_OP_LO  = 83;
  localparam int unsigned IDEX_RS1_HI     = 82;
  localparam int unsigned IDEX_RS1_LO     = 51;
  localparam int unsigned IDEX_RS2_HI     = 50;
  localparam int unsigned IDEX_RS2_LO     = 19;
  localparam int unsigned IDEX_RD_HI      = 18;
  localparam int unsigned IDEX_RD_LO      = 14;
  localparam int unsigned IDEX_RS1_ID_HI  = 13;
  localparam int unsigned IDEX_RS1_ID_LO  = 9;
  localparam int unsigned IDEX_RS2_ID_HI  = 8;
  localparam int unsigned IDEX_RS2_ID_LO  = 4;
  localparam int unsigned IDEX_FUNCT_HI   = 3;
  localparam int unsigned IDEX_FUNCT_LO   = 0;

  // EX/MEM bundle, 76 bits: four control bits, ALU result, store data, rd, flags
  localparam int unsigned EXMEM_W          = 76;
  localparam int unsigned EXMEM_REG_WRITE  = 75;
  localparam int unsigned EXMEM_MEM_TO_REG = 74;
  localparam int unsigned EXMEM_MEM_READ   = 73;
  localparam int unsigned EXMEM_MEM_WRITE  = 72;
  localparam int unsigned EXMEM_ALU_HI     = 71;
  localparam int unsigned EXMEM_ALU_LO     = 40;
  localparam int unsigned EXMEM_STORE_HI   = 39;
  localparam int unsigned EXMEM_STORE_LO   = 8;
  localparam int unsigned EXMEM_RD_HI      = 7;
  localparam int unsigned EXMEM_RD_LO      = 3;
  localparam int unsigned EXMEM_ZERO       = 2;
  localparam int unsigned EXMEM_SIZE_HI    = 1;
  localparam int unsigned EXMEM_SIZE_LO    = 0;

  // Bubbles carry every control bit inactive
  localparam logic [IDEX_W-1:0]  IDEX_NOP  = '0;
  localparam logic [EXMEM_W-1:0] EXMEM_NOP = '0;

  function automatic int unsigned pipe_popcount(input logic [PIPE_MAX_STAGES-1:0] bits);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(PIPE_MAX_STAGES); i++) n += 32'(bits[i]);
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_buffer_if.sv
// Upstream/downstream handshake bundle of the pipeline buffer; the buffer is the slave.
interface pipe_stage_buffer_if #(
  parameter int unsigned WIDTH  = 91,
  parameter int unsigned STAGES = 1
);
  localparam int unsigned CW = $clog2(STAGES + 1);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [STAGES-1:0] flush;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [CW-1:0]     count;
  logic              full;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, count, full
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, count, full
  );
endinterface

// File: rtl/pipe_stage.sv
// One buffer stage: valid + payload register with load, hold, bubble and kill.
module pipe_stage #(
  parameter int unsigned      WIDTH     = 91,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic             load,
  input  logic             kill,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_nxt_c,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic [WIDTH-1:0] d_nxt;

  // Kill wins over load; a ready stage with nothing arriving becomes a bubble
  always_comb begin
    v_nxt_c = v;
    d_nxt   = d;
    if (kill) begin
      v_nxt_c = 1'b0;
      d_nxt   = NOP_VALUE;
    end else if (ready) begin
      v_nxt_c = load;
      d_nxt   = load ? d_in : NOP_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= 1'b0;
      d <= NOP_VALUE;
    end else begin
      v <= v_nxt_c;
      d <= d_nxt;
    end
  end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Chain of STAGES handshaked register stages with bubble collapsing, per-stage flush
// and a registered occupancy count.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 91,
  parameter int unsigned      STAGES    = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input logic clk,
  input logic reset,
  pipe_stage_buffer_if.slave bus
);

  localparam int unsigned CW = $clog2(STAGES + 1);

  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_nxt;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  d     [STAGES];
  logic [WIDTH-1:0]  d_src [STAGES];
  logic [CW-1:0]     count_nxt;
  logic [CW-1:0]     count_q;
  logic              full_q;

  // A stage is ready when empty or when everything downstream of it moves
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = bus.out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) rdy[i] = !v[i] | rdy[i+1];
  end

  for (genvar i = 0; i < int'(STAGES); i++) begin : g_stage
    if (i == 0) begin : g_head
      assign load[i]  = rdy[i] & bus.in_valid;
      assign d_src[i] = bus.in_data;
    end else begin : g_body
      assign load[i]  = rdy[i] & v[i-1];
      assign d_src[i] = d[i-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .NOP_VALUE (NOP_VALUE)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .ready   (rdy[i]),
      .load    (load[i]),
      .kill    (bus.flush[i]),
      .d_in    (d_src[i]),
      .v_nxt_c (v_nxt[i]),
      .v       (v[i]),
      .d       (d[i])
    );
  end

  always_comb count_nxt = CW'(pipe_popcount(PIPE_MAX_STAGES'(v_nxt)));

  // Occupancy registered alongside the stage valids
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(STAGES));
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v[STAGES-1];
  assign bus.out_data  = d[STAGES-1];
  assign bus.count     = count_q;
  assign bus.full      = full_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench for pipe_stage_buffer (STAGES=3, WIDTH=8): directed scenarios
// plus randomized traffic against an occupancy-based reference model.
module tb_pipe_stage_buffer;

  localparam int unsigned W = 8;
  localparam int unsigned S = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: slot contents, slot 2 is the output end
  logic       mv [S];
  logic [7:0] md [S];

  pipe_stage_buffer_if #(.WIDTH(W), .STAGES(S)) bus ();

  pipe_stage_buffer #(
    .WIDTH     (W),
    .STAGES    (S),
    .NOP_VALUE (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned mcount();
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(S); i++) n += mv[i] ? 1 : 0;
    return n;
  endfunction

  // An entry advances whenever any slot at or beyond it is free or the output drains
  task automatic model_step(input logic iv, input logic [7:0] id, input logic ordy,
                            input logic [2:0] fl, input logic rst);
    logic       nv [S];
    logic [7:0] nd [S];
    logic [2:0] can_move;
    logic       hole;
    if (rst) begin
      for (int i = 0; i < int'(S); i++) begin mv[i] = 1'b0; md[i] = 8'h00; end
      return;
    end
    hole = 1'b0;
    for (int i = int'(S) - 1; i >= 0; i--) begin
      hole        = hole | !mv[i];
      can_move[i] = ordy | hole;
    end
    for (int i = 0; i < int'(S); i++) begin
      if (can_move[i]) begin
        if (i == 0) begin nv[i] = iv;      nd[i] = iv ? id : 8'h00; end
        else        begin nv[i] = mv[i-1]; nd[i] = mv[i-1] ? md[i-1] : 8'h00; end
      end else begin
        nv[i] = mv[i];
        nd[i] = md[i];
      end
      if (fl[i]) begin nv[i] = 1'b0; nd[i] = 8'h00; end
    end
    for (int i = 0; i < int'(S); i++) begin mv[i] = nv[i]; md[i] = nd[i]; end
  endtask

  // Drive one cycle, check in_ready before the edge and all registered outputs after it
  task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy,
                       input logic [2:0] fl, input logic rst, output logic ir);
    reset         = rst;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    ir = bus.in_ready;
    check("in_ready", 32'(ir), 32'((mcount() < S) || ordy));
    model_step(iv, id, ordy, fl, rst);
    @(posedge clk);
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(mv[S-1]));
    check("out_data",  32'(bus.out_data),  32'(md[S-1]));
    check("count",     32'(bus.count),     mcount());
    check("full",      32'(bus.full),      32'(mcount() == S));
  endtask

  initial begin
    logic ir;
    logic [2:0] fl;

    // Reset from unknown state
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.flush = '0;
    @(posedge clk); #1;
    model_step(1'b0, 8'h00, 1'b0, 3'b000, 1'b1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data",  32'(bus.out_data),  0);
    check("rst_count",     32'(bus.count),     0);
    check("rst_full",      32'(bus.full),      0);
    reset = 1'b0; #1;
    check("rst_in_ready",  32'(bus.in_ready),  1);

    // Streaming with out_ready held high: 3-cycle latency, then one per cycle
    cycle(1, 8'h11, 1, 3'b000, 0, ir);
    cycle(1, 8'h22, 1, 3'b000, 0, ir);
    cycle(1, 8'h33, 1, 3'b000, 0, ir);
    check("stream_first", 32'(bus.out_data), 32'h11);
    cycle(1, 8'h44, 1, 3'b000, 0, ir);
    check("stream_second", 32'(bus.out_data), 32'h22);
    check("stream_count", 32'(bus.count), 3);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 3'b000, 0, ir);

    // Fill while stalled, then a single-cycle drain
    cycle(1, 8'hA1, 0, 3'b000, 0, ir);
    cycle(1, 8'hA2, 0, 3'b000, 0, ir);
    cycle(1, 8'hA3, 0, 3'b000, 0, ir);
    check("fill_full", 32'(bus.full), 1);
    check("fill_head", 32'(bus.out_data), 32'hA1);
    cycle(0, 8'h00, 0, 3'b000, 0, ir);
    check("fill_in_ready_low", 32'(ir), 0);
    cycle(0, 8'h00, 1, 3'b000, 0, ir);
    check("drain_in_ready_high", 32'(ir), 1);
    check("drain_next_head", 32'(bus.out_data), 32'hA2);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 3'b000, 0, ir);

    // Single item collapses to the output stage while stalled
    cycle(1, 8'h5C, 0, 3'b000, 0, ir);
    cycle(0, 8'h00, 0, 3'b000, 0, ir);
    cycle(0, 8'h00, 0, 3'b000, 0, ir);
    check("collapse_count", 32'(bus.count), 1);
    check("collapse_data", 32'(bus.out_data), 32'h5C);
    cycle(0, 8'h00, 1, 3'b000, 0, ir);

    // Flush the two younger entries; the oldest still leaves
    cycle(1, 8'hB1, 0, 3'b000, 0, ir);
    cycle(1, 8'hB2, 0, 3'b000, 0, ir);
    cycle(1, 8'hB3, 0, 3'b000, 0, ir);
    cycle(0, 8'h00, 0, 3'b011, 0, ir);
    check("flush_keep_b1", 32'(bus.out_data), 32'hB1);
    check("flush_count", 32'(bus.count), 1);
    cycle(0, 8'h00, 1, 3'b000, 0, ir);
    check("flush_empty_count", 32'(bus.count), 0);
    check("flush_empty_data", 32'(bus.out_data), 0);
    cycle(0, 8'h00, 1, 3'b000, 0, ir);
    check("flush_no_b2", 32'(bus.out_valid), 0);

    // Reset with a full buffer and an item on offer
    cycle(1, 8'hC1, 0, 3'b000, 0, ir);
    cycle(1, 8'hC2, 0, 3'b000, 0, ir);
    cycle(1, 8'hC3, 0, 3'b000, 0, ir);
    cycle(1, 8'hDD, 1, 3'b000, 1, ir);
    check("midrst_count", 32'(bus.count), 0);
    check("midrst_valid", 32'(bus.out_valid), 0);
    check("midrst_data", 32'(bus.out_data), 0);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 3'b000, 0, ir);
    check("midrst_not_captured", 32'(bus.out_valid), 0);

    // flush[0] drops an accepted item on an empty buffer
    cycle(1, 8'h77, 1, 3'b001, 0, ir);
    check("flush0_handshake", 32'(ir), 1);
    check("flush0_count", 32'(bus.count), 0);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 3'b000, 0, ir);
    check("flush0_dropped", 32'(bus.out_valid), 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      fl = ($urandom_range(7) == 0) ? 3'($urandom) : 3'b000;
      cycle(1'($urandom), 8'($urandom), ($urandom_range(3) != 0), fl,
            ($urandom_range(63) == 0), ir);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
